// File: rtl/branch_pred_unit.sv
// Next-PC predictor for the y86 fetch stage: 2-bit direction table for jXX plus a
// return address stack with a committed checkpoint that a flush restores.
module branch_pred_unit #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned MODE      = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic [1:0]        pred_src,
  input  logic              e_valid,
  input  logic [ADDR_W-1:0] e_pc,
  input  logic              e_taken,
  input  logic              e_pred_taken,
  input  logic              w_valid,
  input  logic [3:0]        w_icode,
  input  logic              flush,
  output logic [CNT_W-1:0]  lookup_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TblSize = 2 ** IDX_W;
  localparam int unsigned PtrW    = $clog2(RAS_DEPTH);
  localparam int unsigned RasCntW = PtrW + 1;
  localparam logic [RasCntW-1:0] RasFull = RasCntW'(RAS_DEPTH);
  localparam logic [RasCntW-1:0] RasOne  = RasCntW'(1);
  localparam logic [PtrW-1:0]    PtrOne  = PtrW'(1);
  localparam logic [3:0] IJxx  = 4'h7;
  localparam logic [3:0] ICall = 4'h8;
  localparam logic [3:0] IRet  = 4'h9;

  logic [1:0]        tbl_q [TblSize];
  logic [1:0]        tbl_d [TblSize];
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PtrW-1:0]    sp_q, sp_d, cp_q, cp_d;
  logic [RasCntW-1:0] sc_q, sc_d, cc_q, cc_d;
  logic [CNT_W-1:0]   lookup_q, lookup_d, miss_q, miss_d;

  logic              is_jxx, is_call, is_ret, is_cond, cond_taken;
  logic [IDX_W-1:0]  f_idx, e_idx;
  logic [ADDR_W-1:0] ras_top;

  // Only the low PC bits index the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[ADDR_W-1:IDX_W], e_pc[ADDR_W-1:IDX_W]};

  assign is_jxx     = (f_icode == IJxx);
  assign is_call    = (f_icode == ICall);
  assign is_ret     = (f_icode == IRet);
  assign is_cond    = is_jxx && (f_ifun != 4'h0);
  assign f_idx      = f_pc[IDX_W-1:0];
  assign e_idx      = e_pc[IDX_W-1:0];
  assign cond_taken = (MODE == 0) ? 1'b1 : tbl_q[f_idx][1];
  assign ras_top    = ras_q[sp_q - PtrOne];

  always_comb begin
    pred_pc    = f_valP;
    pred_taken = 1'b0;
    pred_src   = 2'd0;
    if (is_jxx) begin
      pred_taken = is_cond ? cond_taken : 1'b1;
      if (pred_taken) begin
        pred_pc  = f_valC;
        pred_src = 2'd1;
      end
    end else if (is_call) begin
      pred_pc  = f_valC;
      pred_src = 2'd1;
    end else if (is_ret) begin
      if (sc_q != '0) begin
        pred_pc  = ras_top;
        pred_src = 2'd2;
      end else begin
        pred_src = 2'd3;
      end
    end
  end

  always_comb begin
    tbl_d = tbl_q;
    if ((MODE != 0) && e_valid) begin
      if (e_taken && (tbl_q[e_idx] != 2'b11)) begin
        tbl_d[e_idx] = tbl_q[e_idx] + 2'b01;
      end else if (!e_taken && (tbl_q[e_idx] != 2'b00)) begin
        tbl_d[e_idx] = tbl_q[e_idx] - 2'b01;
      end
    end
  end

  always_comb begin
    cp_d = cp_q;
    cc_d = cc_q;
    if (w_valid && (w_icode == ICall)) begin
      cp_d = cp_q + PtrOne;
      if (cc_q != RasFull) cc_d = cc_q + RasOne;
    end else if (w_valid && (w_icode == IRet) && (cc_q != '0)) begin
      cp_d = cp_q - PtrOne;
      cc_d = cc_q - RasOne;
    end
  end

  // Flush rewinds to the checkpoint as it stands after this cycle's commit.
  always_comb begin
    ras_d = ras_q;
    sp_d  = sp_q;
    sc_d  = sc_q;
    if (flush) begin
      sp_d = cp_d;
      sc_d = cc_d;
    end else if (f_valid && is_call) begin
      ras_d[sp_q] = f_valP;
      sp_d        = sp_q + PtrOne;
      if (sc_q != RasFull) sc_d = sc_q + RasOne;
    end else if (f_valid && is_ret && (sc_q != '0)) begin
      sp_d = sp_q - PtrOne;
      sc_d = sc_q - RasOne;
    end
  end

  always_comb begin
    lookup_d = lookup_q;
    miss_d   = miss_q;
    if (f_valid && !flush && is_cond && !(&lookup_q)) lookup_d = lookup_q + 1'b1;
    if (e_valid && (e_taken != e_pred_taken) && !(&miss_q)) miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TblSize; i++) tbl_q[i] <= 2'b10;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      sp_q     <= '0;
      sc_q     <= '0;
      cp_q     <= '0;
      cc_q     <= '0;
      lookup_q <= '0;
      miss_q   <= '0;
    end else begin
      tbl_q    <= tbl_d;
      ras_q    <= ras_d;
      sp_q     <= sp_d;
      sc_q     <= sc_d;
      cp_q     <= cp_d;
      cc_q     <= cc_d;
      lookup_q <= lookup_d;
      miss_q   <= miss_d;
    end
  end

  assign lookup_cnt = lookup_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Bench for branch_pred_unit: a dynamic 32-bit-counter instance and a static 4-bit-counter
// instance share stimulus; directed scenarios plus a randomized run against a reference model.
module tb_branch_pred_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        f_valid, e_valid, e_taken, e_pred_taken, w_valid, flush;
  logic [63:0] f_pc, f_valC, f_valP, e_pc;
  logic [3:0]  f_icode, f_ifun, w_icode;

  logic [63:0] pp1, pp0;
  logic        pt1, pt0;
  logic [1:0]  ps1, ps0;
  logic [31:0] lk1, ms1;
  logic [3:0]  lk0, ms0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          cnt [16];
  logic [63:0] ras [8];
  int          sp, sc, cp, cc;
  int unsigned lk1m, ms1m, lk0m, ms0m;

  branch_pred_unit #(.MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .f_valid(f_valid), .f_pc(f_pc), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .pred_pc(pp1), .pred_taken(pt1),
    .pred_src(ps1), .e_valid(e_valid), .e_pc(e_pc), .e_taken(e_taken),
    .e_pred_taken(e_pred_taken), .w_valid(w_valid), .w_icode(w_icode), .flush(flush),
    .lookup_cnt(lk1), .miss_cnt(ms1)
  );

  branch_pred_unit #(.MODE(0), .CNT_W(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .f_valid(f_valid), .f_pc(f_pc), .f_icode(f_icode),
    .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP), .pred_pc(pp0), .pred_taken(pt0),
    .pred_src(ps0), .e_valid(e_valid), .e_pc(e_pc), .e_taken(e_taken),
    .e_pred_taken(e_pred_taken), .w_valid(w_valid), .w_icode(w_icode), .flush(flush),
    .lookup_cnt(lk0), .miss_cnt(ms0)
  );

  always #5 clock = ~clock;

  task automatic model_reset;
    for (int i = 0; i < 16; i++) cnt[i] = 2;
    for (int i = 0; i < 8; i++) ras[i] = '0;
    sp = 0; sc = 0; cp = 0; cc = 0;
    lk1m = 0; ms1m = 0; lk0m = 0; ms0m = 0;
  endtask

  function automatic void model_pred(input int mode, output logic [63:0] pc, output logic tk,
                                     output logic [1:0] src);
    pc = f_valP; tk = 1'b0; src = 2'd0;
    if (f_icode == 4'd7) begin
      if (f_ifun == 4'd0) tk = 1'b1;
      else tk = (mode == 0) ? 1'b1 : (cnt[f_pc[3:0]] >= 2);
      if (tk) begin pc = f_valC; src = 2'd1; end
    end else if (f_icode == 4'd8) begin
      pc = f_valC; src = 2'd1;
    end else if (f_icode == 4'd9) begin
      if (sc > 0) begin pc = ras[(sp + 7) % 8]; src = 2'd2; end
      else src = 2'd3;
    end
  endfunction

  task automatic model_update;
    int idx;
    idx = int'(e_pc[3:0]);
    if (e_valid) begin
      if (e_taken) cnt[idx] = (cnt[idx] < 3) ? cnt[idx] + 1 : 3;
      else cnt[idx] = (cnt[idx] > 0) ? cnt[idx] - 1 : 0;
      if (e_taken != e_pred_taken) begin
        ms1m++;
        if (ms0m < 15) ms0m++;
      end
    end
    if (w_valid && w_icode == 4'd8) begin
      cp = (cp + 1) % 8;
      if (cc < 8) cc++;
    end else if (w_valid && w_icode == 4'd9 && cc > 0) begin
      cp = (cp + 7) % 8;
      cc--;
    end
    if (flush) begin
      sp = cp; sc = cc;
    end else if (f_valid) begin
      if (f_icode == 4'd8) begin
        ras[sp] = f_valP;
        sp = (sp + 1) % 8;
        if (sc < 8) sc++;
      end else if (f_icode == 4'd9 && sc > 0) begin
        sp = (sp + 7) % 8;
        sc--;
      end
      if (f_icode == 4'd7 && f_ifun != 4'd0) begin
        lk1m++;
        if (lk0m < 15) lk0m++;
      end
    end
  endtask

  task automatic tick;
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle;
    f_valid = 0; f_pc = '0; f_icode = 4'd1; f_ifun = '0; f_valC = '0; f_valP = '0;
    e_valid = 0; e_pc = '0; e_taken = 0; e_pred_taken = 0;
    w_valid = 0; w_icode = '0; flush = 0;
  endtask

  task automatic do_reset;
    idle();
    reset_n = 1'b0;
    model_reset();
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] pc,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_valid = 1; f_icode = ic; f_ifun = fn; f_pc = pc; f_valC = vc; f_valP = vp;
  endtask

  task automatic test_reset;
    do_reset();
    f_icode = 4'd9; f_valP = 64'h77;
    #1;
    checks++;
    if ({lk1, ms1, lk0, ms0} !== 72'd0) begin
      errors++;
      $display("FAIL reset_counters: got %h %h %h %h required all zero", lk1, ms1, lk0, ms0);
    end
    checks++;
    if ({pp1, ps1} !== {64'h77, 2'd3}) begin
      errors++;
      $display("FAIL reset_ras_empty: got pc=%h src=%0d required pc=77 src=3", pp1, ps1);
    end
  endtask

  task automatic test_cond_jump;
    do_reset();
    fetch(4'd7, 4'd1, 64'h10, 64'h40, 64'h19);
    #1;
    checks++;
    if ({pp1, pt1, ps1} !== {64'h40, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL first_jxx: got pc=%h t=%b src=%0d required 40 1 1", pp1, pt1, ps1);
    end
    tick();
    checks++;
    if (lk1 !== 32'd1) begin
      errors++;
      $display("FAIL lookup_cnt_one: got %0d required 1", lk1);
    end
    f_valid = 0;
    e_valid = 1; e_pc = 64'h10; e_taken = 0; e_pred_taken = 1;
    tick();
    tick();
    e_valid = 0;
    f_valid = 1;
    #1;
    checks++;
    if ({pp1, pt1, ps1} !== {64'h19, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL trained_not_taken: got pc=%h t=%b src=%0d required 19 0 0", pp1, pt1, ps1);
    end
    checks++;
    if ({pp0, pt0, ps0} !== {64'h40, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL static_mode: got pc=%h t=%b src=%0d required 40 1 1", pp0, pt0, ps0);
    end
    checks++;
    if (ms1 !== 32'd2) begin
      errors++;
      $display("FAIL miss_cnt_two: got %0d required 2", ms1);
    end
    // Same-index update and lookup: prediction must use the pre-update counter.
    e_valid = 1; e_taken = 1; e_pred_taken = 0;
    #1;
    checks++;
    if (pp1 !== 64'h19) begin
      errors++;
      $display("FAIL same_cycle_lookup: got %h required 19", pp1);
    end
    tick();
    tick();
    e_valid = 0;
    #1;
    checks++;
    if (pp1 !== 64'h40) begin
      errors++;
      $display("FAIL retrained_taken: got %h required 40", pp1);
    end
    f_valid = 0;
  endtask

  task automatic test_ras;
    do_reset();
    fetch(4'd8, 4'd0, 64'h0, 64'h500, 64'h2A);
    #1;
    checks++;
    if ({pp1, ps1} !== {64'h500, 2'd1}) begin
      errors++;
      $display("FAIL call_pred: got pc=%h src=%0d required 500 1", pp1, ps1);
    end
    tick();
    fetch(4'd9, 4'd0, 64'h0, 64'h0, 64'h33);
    #1;
    checks++;
    if ({pp1, ps1} !== {64'h2A, 2'd2}) begin
      errors++;
      $display("FAIL ret_pred: got pc=%h src=%0d required 2a 2", pp1, ps1);
    end
    tick();
    f_valP = 64'h44;
    #1;
    checks++;
    if ({pp1, ps1} !== {64'h44, 2'd3}) begin
      errors++;
      $display("FAIL ret_empty: got pc=%h src=%0d required 44 3", pp1, ps1);
    end
    f_valid = 0;
  endtask

  task automatic test_ras_overflow;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fetch(4'd8, 4'd0, 64'h0, 64'h800, 64'h100 + 64'(i));
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      fetch(4'd9, 4'd0, 64'h0, 64'h0, 64'hF00);
      #1;
      checks++;
      if (i < 8 && {pp1, ps1} !== {64'h108 - 64'(i), 2'd2}) begin
        errors++;
        $display("FAIL ras_wrap_%0d: got pc=%h src=%0d required %h 2", i, pp1, ps1, 64'h108 - 64'(i));
      end else if (i == 8 && {pp1, ps1} !== {64'hF00, 2'd3}) begin
        errors++;
        $display("FAIL ras_wrap_empty: got pc=%h src=%0d required f00 3", pp1, ps1);
      end
      tick();
    end
    f_valid = 0;
  endtask

  task automatic test_flush;
    do_reset();
    fetch(4'd8, 4'd0, 64'h0, 64'h900, 64'h50);
    tick();
    f_valP = 64'h58;
    tick();
    f_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    fetch(4'd9, 4'd0, 64'h0, 64'h0, 64'hA0);
    #1;
    checks++;
    if (ps1 !== 2'd3) begin
      errors++;
      $display("FAIL flush_no_commit: got src=%0d required 3", ps1);
    end
    do_reset();
    fetch(4'd8, 4'd0, 64'h0, 64'h900, 64'h60);
    tick();
    f_valP = 64'h68;
    tick();
    f_valid = 0;
    w_valid = 1; w_icode = 4'd8; flush = 1;
    tick();
    w_valid = 0; flush = 0;
    fetch(4'd9, 4'd0, 64'h0, 64'h0, 64'hA0);
    #1;
    checks++;
    if ({pp1, ps1} !== {64'h60, 2'd2}) begin
      errors++;
      $display("FAIL flush_commit: got pc=%h src=%0d required 60 2", pp1, ps1);
    end
    f_valid = 0;
  endtask

  task automatic test_async_reset;
    do_reset();
    e_valid = 1; e_pc = 64'h10; e_taken = 0; e_pred_taken = 1;
    tick();
    tick();
    e_valid = 0;
    fetch(4'd8, 4'd0, 64'h0, 64'h900, 64'h70);
    tick();
    fetch(4'd7, 4'd1, 64'h10, 64'h40, 64'h19);
    f_valid = 0;
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pp1, ms1, lk1} !== {64'h40, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset_clear: got pc=%h miss=%0d lookup=%0d required 40 0 0", pp1, ms1, lk1);
    end
    f_icode = 4'd9; f_valP = 64'h55;
    #1;
    checks++;
    if (ps1 !== 2'd3) begin
      errors++;
      $display("FAIL async_reset_ras: got src=%0d required 3", ps1);
    end
    reset_n = 1'b1;
    idle();
    e_valid = 1; e_pc = 64'h3; e_taken = 1; e_pred_taken = 0;
    tick();
    e_valid = 0;
    checks++;
    if (ms1 !== 32'd1) begin
      errors++;
      $display("FAIL miss_after_reset: got %0d required 1", ms1);
    end
  endtask

  task automatic test_random;
    logic [63:0] epc;
    logic        etk;
    logic [1:0]  esrc;
    int          r;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      f_icode = (r < 4) ? 4'd7 : (r < 6) ? 4'd8 : (r < 8) ? 4'd9 : 4'($urandom_range(0, 6));
      f_ifun  = 4'($urandom_range(0, 3));
      f_valid = ($urandom_range(0, 3) != 0);
      f_pc    = {$urandom, $urandom};
      f_valC  = {$urandom, $urandom};
      f_valP  = {$urandom, $urandom};
      e_valid = $urandom_range(0, 1) == 1;
      e_pc    = 64'($urandom);
      e_taken = $urandom_range(0, 1) == 1;
      e_pred_taken = $urandom_range(0, 1) == 1;
      w_valid = $urandom_range(0, 1) == 1;
      w_icode = 4'($urandom_range(7, 10));
      flush   = ($urandom_range(0, 15) == 0);
      #1;
      model_pred(1, epc, etk, esrc);
      checks++;
      if ({pp1, pt1, ps1} !== {epc, etk, esrc}) begin
        errors++;
        $display("FAIL rand_pred_dyn@%0d: got %h %b %0d required %h %b %0d",
                 n, pp1, pt1, ps1, epc, etk, esrc);
      end
      model_pred(0, epc, etk, esrc);
      checks++;
      if ({pp0, pt0, ps0} !== {epc, etk, esrc}) begin
        errors++;
        $display("FAIL rand_pred_static@%0d: got %h %b %0d required %h %b %0d",
                 n, pp0, pt0, ps0, epc, etk, esrc);
      end
      tick();
      checks++;
      if ({lk1, ms1, lk0, ms0} !== {lk1m, ms1m, 4'(lk0m), 4'(ms0m)}) begin
        errors++;
        $display("FAIL rand_counters@%0d: got %0d %0d %0d %0d required %0d %0d %0d %0d",
                 n, lk1, ms1, lk0, ms0, lk1m, ms1m, lk0m, ms0m);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_cond_jump();
    test_ras();
    test_ras_overflow();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
- Parametrised next-PC predictor for the y86 pipelined core; replaces the fixed always-taken / valP rule in fetch.
- Inputs are the instruction fields decoded in fetch; output is the predicted PC that fetch registers into F_predPC.
- Contains a 2-bit saturating direction table for jXX and a return address stack (RAS) for call/ret.
- Trained from execute (branch outcome) and write-back (commit); supports a flush checkpoint for the RAS.

Parameters:
- ADDR_W, 64, PC width.
- IDX_W, 4, direction-table index bits; table has 2**IDX_W entries.
- RAS_DEPTH, 8, RAS entries (power of 2, >=2).
- MODE, 1, 0 = static always-taken (table ignored); 1 = dynamic 2-bit.
- CNT_W, 32, width of the performance counters.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- f_valid  in  1  fetch presents a new instruction this cycle (low when F_stall).
- f_pc  in  ADDR_W  PC of the fetched instruction.
- f_icode  in  4  fetched icode (7=jXX, 8=call, 9=ret).
- f_ifun  in  4  fetched ifun (0 = unconditional jmp).
- f_valC  in  ADDR_W  jump/call target.
- f_valP  in  ADDR_W  fall-through PC.
- pred_pc  out  ADDR_W  predicted next PC (combinational).
- pred_taken  out  1  prediction for a conditional jXX (combinational).
- pred_src  out  2  0=valP, 1=valC, 2=RAS top, 3=RAS empty fallback (valP).
- e_valid  in  1  execute holds a resolving conditional jXX.
- e_pc  in  ADDR_W  PC of that jXX.
- e_taken  in  1  actual outcome (e_Cnd).
- e_pred_taken  in  1  prediction carried down the pipe for that jXX.
- w_valid  in  1  write-back commits an instruction.
- w_icode  in  4  committed icode.
- flush  in  1  mispredict/exception flush; restores the RAS checkpoint.
- lookup_cnt  out  CNT_W  conditional jXX predictions made.
- miss_cnt  out  CNT_W  conditional jXX mispredictions.

Behaviour:
- Reset (async, reset_n=0):
  - All table counters = 2'b10 (weakly taken).
  - RAS spec pointer/count and committed pointer/count = 0; RAS entries = 0.
  - lookup_cnt = miss_cnt = 0.
  - Outputs are then driven combinationally from the reset state.
- Table index = least-significant IDX_W bits of PC: bits [ADDR_W-IDX_W : ADDR_W-1] in the codebase's [0:N] ordering.
- Prediction (zero latency, combinational):
  - jXX with ifun=0: pred_pc=valC, pred_taken=1, src=1.
  - jXX with ifun!=0:
    - MODE=0: pred_taken=1.
    - MODE=1: pred_taken = counter MSB.
    - pred_pc = taken ? valC : valP; src = taken ? 1 : 0.
  - call: pred_pc=valC, src=1.
  - ret with RAS count>0: pred_pc=RAS top, src=2.
  - ret with RAS empty: pred_pc=valP, src=3.
  - All other icodes: pred_pc=valP, src=0, pred_taken=0.
- RAS speculative update, only when f_valid=1 and flush=0:
  - call: push f_valP; ptr=ptr+1 mod RAS_DEPTH; count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten (wrap).
  - ret with count>0: ptr-1, count-1.
  - ret with count=0: no change.
- Committed checkpoint (ptr, count): updated by the same rules on w_valid with w_icode 8/9; entries are not touched.
- flush=1: spec ptr/count <- committed ptr/count, including any commit in the same cycle. Any f_valid push/pop that cycle is dropped. Entries are not restored.
- Table training: e_valid=1, MODE=1 → counter[e_pc idx] += 1 if e_taken (saturate at 3), else -= 1 (saturate at 0). MODE=0: no training.
- Same-index lookup and update in one cycle: the lookup sees the pre-update counter.
- lookup_cnt +1 on f_valid with a conditional jXX (not during flush).
- miss_cnt +1 on e_valid with e_taken != e_pred_taken.
- Both counters saturate at all-ones and never wrap.

Test Plan:
- Reset, then f_icode=7, ifun=1, f_pc=0x10, valC=0x40, valP=0x19 → pred_pc=0x40, pred_taken=1, src=1. lookup_cnt becomes 1 after the clock.
- Two e_valid not-taken updates at e_pc=0x10 (counter 2→1→0), then refetch at 0x10 → pred_pc=0x19, src=0. Same sequence with MODE=0 → still 0x40.
- call at valP=0x2A, then ret → pred_pc=0x2A, src=2. A second ret → src=3, pred_pc=its valP.
- RAS_DEPTH=8: nine calls with valP 0x100..0x108, then nine rets → first eight return 0x108 down to 0x101, ninth gives src=3.
- Two spec calls with no commits, then flush=1 → next ret gives src=3. With one call committed via w_valid before the flush → ret gives src=2.
- Assert reset_n mid-sequence (async, between clock edges) → counters, RAS and perf counters clear immediately. e_valid with e_taken=1 and e_pred_taken=0 → miss_cnt=1.
